mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction fetch unit and
//   the load/store unit. At most one read is outstanding at a time. The LSU
//   normally wins over fetch. An optional starvation guard lets a waiting
//   fetch through after STARVE_LIMIT consecutive LSU grants.
//
//   Build option: define ARB_STARVE_GUARD_EN to enable the starvation guard.
//   When it is undefined, LSU priority is strict and the guard counter is
//   not built.
//
// Handshake: a requester holds req (and its address/data) until it sees gnt
//   high in the same cycle. gnt is combinational and is only given when the
//   memory is free: in IDLE, or in the cycle the outstanding read returns.
//   Responses (*_rvalid/*_rdata) are registered single-cycle pulses with no
//   back-pressure.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   if_req/if_addr        fetch read request, byte address
//   if_flush              fetch redirect; kills undelivered fetch work
//   if_gnt                fetch request accepted this cycle
//   if_rvalid/if_rdata    fetch read response
//   ls_req/ls_wen         LSU request, 1 = store
//   ls_addr/ls_wdata      LSU byte address, store data
//   ls_gnt                LSU request accepted this cycle
//   ls_rvalid/ls_rdata    LSU load response
//   mem_ren/mem_wen       one-cycle memory read/write strobes
//   mem_addr/mem_wdata    doubleword-aligned address, store data
//   mem_rvalid/mem_rdata  memory read return

module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [63:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_wen,
    input  logic [63:0] ls_addr,
    input  logic [63:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [63:0] ls_rdata,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    // A limit of zero would let fetch pre-empt the LSU permanently.
    if (STARVE_LIMIT < 1) begin : g_limit_check
        $error("STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2,
        DRAIN   = 2'd3   // flushed fetch read still in flight; swallow its data
    } state_t;

    state_t state;
    state_t state_next;

    logic can_grant;
    logic fetch_first;
    logic deliver_if;
    logic deliver_ls;

    // ------------------------------------------------------------------
    // Starvation guard
    // ------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign fetch_first = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    // Counts LSU wins over a live fetch request; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || if_gnt || !if_req) begin
            starve_cnt <= '0;
        end else if (ls_gnt && !if_flush && !fetch_first) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    assign fetch_first = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = IDLE;
            BUSY_IF: begin
                if (mem_rvalid)    state_next = IDLE;
                else if (if_flush) state_next = DRAIN;
            end
            BUSY_LS: if (mem_rvalid) state_next = IDLE;
            DRAIN:   if (mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A grant (possible in the return cycle) overrides the return to IDLE.
        if (if_gnt) begin
            state_next = BUSY_IF;
        end else if (ls_gnt && !ls_wen) begin
            state_next = BUSY_LS;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (grants and response qualifiers)
    // ------------------------------------------------------------------
    always_comb begin
        // The memory is free in IDLE, or in the cycle a live read returns;
        // DRAIN never re-grants, even when its discarded data arrives.
        can_grant  = (state == IDLE) ||
                     (((state == BUSY_IF) || (state == BUSY_LS)) && mem_rvalid);
        if_gnt     = !rst && can_grant && if_req && !if_flush &&
                     (!ls_req || fetch_first);
        ls_gnt     = !rst && can_grant && ls_req && !if_gnt;
        deliver_if = (state == BUSY_IF) && mem_rvalid && !if_flush;
        deliver_ls = (state == BUSY_LS) && mem_rvalid;
    end

    // ------------------------------------------------------------------
    // Registered memory command and response outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            mem_ren   <= if_gnt || (ls_gnt && !ls_wen);
            mem_wen   <= ls_gnt && ls_wen;
            mem_addr  <= if_gnt ? (if_addr & ~64'h7) :
                         ls_gnt ? (ls_addr & ~64'h7) : '0;
            mem_wdata <= ls_gnt ? ls_wdata : '0;
            if_rvalid <= deliver_if;
            if_rdata  <= deliver_if ? mem_rdata : '0;
            ls_rvalid <= deliver_ls;
            ls_rdata  <= deliver_ls ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized traffic, each cycle compared
//   with a transaction-level reference model of the arbiter.

module tb_mem_port_arbiter;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req, ls_wen, ls_gnt, ls_rvalid;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_ren, mem_wen, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    // ------------------------------------------------------------------
    // Scoreboard and reference model
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];  // expected memory command addresses, in order

    // Who owns the single memory read in flight.
    localparam int OWN_NONE = 0, OWN_FETCH = 1, OWN_LSU = 2, OWN_KILLED = 3;
    int  own         = OWN_NONE;
    int  cnt         = 0;
    bit  model_valid = 1'b0;

    // Expected registered outputs for the current cycle.
    logic        e_ren = 1'b0, e_wen = 1'b0, e_ifv = 1'b0, e_lsv = 1'b0;
    logic [63:0] e_wdata = '0, e_ifd = '0, e_lsd = '0;

    // Snapshot of DUT outputs taken mid-cycle.
    logic        s_if_gnt, s_ls_gnt, s_if_rvalid, s_ls_rvalid, s_mem_ren, s_mem_wen;
    logic [63:0] s_if_rdata, s_ls_rdata, s_mem_addr, s_mem_wdata;

    // Stimulus-side state.
    bit  auto_mem    = 1'b0;
    int  mem_wait    = 0;
    bit  last_if_gnt = 1'b0, last_ls_gnt = 1'b0, last_flush = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already applied. Sample at the falling
    // edge, compare, advance the model, then return just after the rising edge.
    task automatic tick();
        logic can, ffirst, x_if, x_ls;
        logic [63:0] exp_addr;
        @(negedge clk);
        s_if_gnt    = if_gnt;    s_ls_gnt    = ls_gnt;
        s_if_rvalid = if_rvalid; s_if_rdata  = if_rdata;
        s_ls_rvalid = ls_rvalid; s_ls_rdata  = ls_rdata;
        s_mem_ren   = mem_ren;   s_mem_wen   = mem_wen;
        s_mem_addr  = mem_addr;  s_mem_wdata = mem_wdata;

        can    = !rst && (own == OWN_NONE ||
                          (mem_rvalid && (own == OWN_FETCH || own == OWN_LSU)));
        ffirst = GUARD && (cnt >= LIMIT);
        x_if   = can && if_req && !if_flush && (!ls_req || ffirst);
        x_ls   = can && ls_req && !x_if;

        check("if_gnt", s_if_gnt, x_if);
        check("ls_gnt", s_ls_gnt, x_ls);
        if (model_valid) begin
            check("mem_ren",   s_mem_ren,   e_ren);
            check("mem_wen",   s_mem_wen,   e_wen);
            check("mem_wdata", s_mem_wdata, e_wdata);
            check("if_rvalid", s_if_rvalid, e_ifv);
            check("ls_rvalid", s_ls_rvalid, e_lsv);
            if (e_ifv) check("if_rdata", s_if_rdata, e_ifd);
            if (e_lsv) check("ls_rdata", s_ls_rdata, e_lsd);
            if (s_mem_ren || s_mem_wen) begin
                if (exp_q.size() == 0) begin
                    check("mem_cmd_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_addr = exp_q.pop_front();
                    check("mem_addr", s_mem_addr, exp_addr);
                end
            end
        end

        if (auto_mem && s_mem_ren) mem_wait = $urandom_range(1, 3);

        if (rst) begin
            e_ren = 0; e_wen = 0; e_wdata = '0;
            e_ifv = 0; e_lsv = 0; e_ifd = '0; e_lsd = '0;
            own = OWN_NONE; cnt = 0; mem_wait = 0;
            exp_q.delete();
        end else begin
            e_ren   = x_if || (x_ls && !ls_wen);
            e_wen   = x_ls && ls_wen;
            e_wdata = x_ls ? ls_wdata : '0;
            if (x_if)      exp_q.push_back(if_addr & ~64'h7);
            else if (x_ls) exp_q.push_back(ls_addr & ~64'h7);
            e_ifv = (own == OWN_FETCH) && mem_rvalid && !if_flush;
            e_lsv = (own == OWN_LSU) && mem_rvalid;
            e_ifd = mem_rdata;
            e_lsd = mem_rdata;
            if (x_if || !if_req) cnt = 0;
            else if (x_ls && !if_flush && cnt < LIMIT) cnt = cnt + 1;
            if (x_if)                 own = OWN_FETCH;
            else if (x_ls && !ls_wen) own = OWN_LSU;
            else if (own != OWN_NONE && mem_rvalid) own = OWN_NONE;
            else if (own == OWN_FETCH && if_flush)  own = OWN_KILLED;
        end
        model_valid = 1'b1;
        last_if_gnt = x_if;
        last_ls_gnt = x_ls;
        last_flush  = if_flush;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic drive_mem();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (mem_wait > 0) begin
            mem_wait--;
            if (mem_wait == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = {$urandom, $urandom};
            end
        end
    endtask

    task automatic drive_random();
        rst = ($urandom_range(0, 299) == 0);
        if (!if_req || last_if_gnt || last_flush) begin
            if_req  = ($urandom_range(0, 99) < 60);
            if_addr = {$urandom, $urandom};
        end
        if (!ls_req || last_ls_gnt) begin
            ls_req   = ($urandom_range(0, 99) < 50);
            ls_wen   = ($urandom_range(0, 3) == 0);
            ls_addr  = {$urandom, $urandom};
            ls_wdata = {$urandom, $urandom};
        end
        if_flush = ($urandom_range(0, 99) < 8);
        drive_mem();
    endtask

    // ------------------------------------------------------------------
    // Directed then random stimulus
    // ------------------------------------------------------------------
    bit gseq[10];
    int n;

    initial begin
        rst = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
        ls_req = 0; ls_wen = 0; ls_addr = '0; ls_wdata = '0;
        mem_rvalid = 0; mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Reset state
        check("rst_mem_ren",   s_mem_ren,   1'b0);
        check("rst_mem_addr",  s_mem_addr,  64'h0);
        check("rst_if_rvalid", s_if_rvalid, 1'b0);
        check("rst_ls_rvalid", s_ls_rvalid, 1'b0);

        // Fetch only, memory answers two cycles after mem_ren
        if_req = 1; if_addr = 64'h1004;
        tick();
        check("f_gnt", s_if_gnt, 1'b1);
        if_req = 0;
        tick();
        check("f_ren",  s_mem_ren,  1'b1);
        check("f_addr", s_mem_addr, 64'h1000);
        tick();
        check("f_ren_pulse", s_mem_ren, 1'b0);
        mem_rvalid = 1; mem_rdata = 64'hAABB;
        tick();
        check("f_no_early_rvalid", s_if_rvalid, 1'b0);
        mem_rvalid = 0; mem_rdata = '0;
        tick();
        check("f_rvalid", s_if_rvalid, 1'b1);
        check("f_rdata",  s_if_rdata,  64'hAABB);

        // Simultaneous requests: LSU load first, fetch in the return cycle
        if_req = 1; if_addr = 64'h1100;
        ls_req = 1; ls_wen = 0; ls_addr = 64'h2008; ls_wdata = '0;
        tick();
        check("sim_ls_gnt", s_ls_gnt, 1'b1);
        check("sim_if_gnt", s_if_gnt, 1'b0);
        ls_req = 0;
        tick();
        check("sim_ls_addr", s_mem_addr, 64'h2008);
        mem_rvalid = 1; mem_rdata = 64'h1234;
        tick();
        check("sim_if_regrant", s_if_gnt, 1'b1);
        if_req = 0; mem_rvalid = 0;
        tick();
        check("sim_ls_rvalid", s_ls_rvalid, 1'b1);
        check("sim_ls_rdata",  s_ls_rdata,  64'h1234);
        check("sim_if_addr",   s_mem_addr,  64'h1100);
        mem_rvalid = 1; mem_rdata = 64'h77;
        tick();
        mem_rvalid = 0;
        tick();
        check("sim_if_rdata", s_if_rdata, 64'h77);

        // Store
        ls_req = 1; ls_wen = 1; ls_addr = 64'h30; ls_wdata = 64'h55;
        tick();
        check("st_gnt", s_ls_gnt, 1'b1);
        ls_req = 0; ls_wen = 0;
        tick();
        check("st_wen",   s_mem_wen,   1'b1);
        check("st_ren",   s_mem_ren,   1'b0);
        check("st_wdata", s_mem_wdata, 64'h55);
        check("st_addr",  s_mem_addr,  64'h30);
        if_req = 1; if_addr = 64'h40;
        tick();
        check("st_idle_regrant", s_if_gnt, 1'b1);
        check("st_no_rvalid",    s_ls_rvalid, 1'b0);
        check("st_wen_pulse",    s_mem_wen, 1'b0);

        // Flush in BUSY_IF, memory answers three cycles later
        if_req = 0; if_flush = 1;
        tick();
        if_flush = 0; if_req = 1; if_addr = 64'h48;
        tick();
        check("fl_no_gnt1", s_if_gnt, 1'b0);
        tick();
        check("fl_no_gnt2", s_if_gnt, 1'b0);
        mem_rvalid = 1; mem_rdata = 64'hDEAD;
        tick();
        check("fl_no_gnt_drain_rvalid", s_if_gnt, 1'b0);
        mem_rvalid = 0;
        tick();
        check("fl_gnt_after", s_if_gnt, 1'b1);
        check("fl_no_rvalid", s_if_rvalid, 1'b0);
        if_req = 0;
        tick();
        check("fl_new_addr", s_mem_addr, 64'h48);
        mem_rvalid = 1; mem_rdata = 64'h99;
        tick();
        mem_rvalid = 0;
        tick();
        check("fl_new_rdata", s_if_rdata, 64'h99);

        // Reset during BUSY_LS, late memory data is ignored
        ls_req = 1; ls_wen = 0; ls_addr = 64'h500;
        tick();
        ls_req = 0;
        tick();
        rst = 1;
        tick();
        rst = 0; mem_rvalid = 1; mem_rdata = 64'hBAD;
        tick();
        check("rs_mem_ren",   s_mem_ren,   1'b0);
        check("rs_mem_addr",  s_mem_addr,  64'h0);
        check("rs_ls_rvalid", s_ls_rvalid, 1'b0);
        mem_rvalid = 0;
        tick();
        check("rs_late_rvalid", s_ls_rvalid, 1'b0);

        // Continuous LSU stores against a waiting fetch
        auto_mem = 1;
        if_req = 1; if_addr = 64'h2000;
        ls_req = 1; ls_wen = 1; ls_addr = 64'h3000; ls_wdata = 64'h1;
        n = 0;
        for (int c = 0; c < 80 && n < 10; c++) begin
            drive_mem();
            tick();
            if (s_ls_gnt)      begin gseq[n] = 1'b0; n++; end
            else if (s_if_gnt) begin gseq[n] = 1'b1; n++; end
        end
        check("sv_grant_count", n, 10);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("sv_grant_%0d", k), gseq[k], GUARD && (k % 5 == 4));
        end
        if_req = 0; ls_req = 0; ls_wen = 0;
        for (int c = 0; c < 6; c++) begin
            drive_mem();
            tick();
        end

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
